// File: rtl/track_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | track_sequencer: sprite position owner, manual (WASD) or auto lap walk     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module track_sequencer #(
    parameter int X_CENTER = 370,
    parameter int Y_CENTER = 190,
    parameter int TRACK_L  = 270,
    parameter int TRACK_R  = 370,
    parameter int TRACK_T  = 190,
    parameter int TRACK_B  = 290,
    parameter int STEP     = 1,
    parameter int SIZE     = 8,
    parameter int X_MAX    = 639,
    parameter int Y_MAX    = 479,
    parameter int LAP_W    = 8
) (
    input  logic             frame_clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic [7:0]       keycode,
    output logic [9:0]       BallX,
    output logic [9:0]       BallY,
    output logic [9:0]       BallS,
    output logic [2:0]       dir,
    output logic             auto_active,
    output logic [LAP_W-1:0] lap_count,
    output logic             lap_done,
    output logic             oob
);

    typedef enum logic [2:0] {
        S_MANUAL = 3'd0,
        S_LEFT   = 3'd1,
        S_DOWN   = 3'd2,
        S_RIGHT  = 3'd3,
        S_UP     = 3'd4
    } state_t;

    localparam logic [7:0] c_KEY_A     = 8'h04;
    localparam logic [7:0] c_KEY_D     = 8'h07;
    localparam logic [7:0] c_KEY_W     = 8'h1A;
    localparam logic [7:0] c_KEY_S     = 8'h16;
    localparam logic [7:0] c_KEY_ESC   = 8'h29;
    localparam logic [7:0] c_KEY_SPACE = 8'h2C;

    localparam logic signed [11:0] c_X_CENTER = 12'(X_CENTER);
    localparam logic signed [11:0] c_Y_CENTER = 12'(Y_CENTER);
    localparam logic signed [11:0] c_TRACK_L  = 12'(TRACK_L);
    localparam logic signed [11:0] c_TRACK_R  = 12'(TRACK_R);
    localparam logic signed [11:0] c_TRACK_T  = 12'(TRACK_T);
    localparam logic signed [11:0] c_TRACK_B  = 12'(TRACK_B);
    localparam logic signed [11:0] c_STEP     = 12'(STEP);
    localparam logic signed [11:0] c_SIZE     = 12'(SIZE);
    localparam logic signed [11:0] c_X_MAX    = 12'(X_MAX);
    localparam logic signed [11:0] c_Y_MAX    = 12'(Y_MAX);

    state_t                   r_state;
    logic        [9:0]        r_x;
    logic        [9:0]        r_y;
    logic signed [1:0]        r_mx;
    logic signed [1:0]        r_my;
    logic        [7:0]        r_prev_key;
    logic                     r_auto;
    logic        [LAP_W-1:0]  r_lap;
    logic                     r_lap_done;
    logic                     r_oob;

    logic signed [11:0] w_x;
    logic signed [11:0] w_y;
    logic signed [11:0] w_nx;
    logic signed [11:0] w_ny;
    logic signed [11:0] w_left;
    logic signed [11:0] w_down;
    logic signed [11:0] w_right;
    logic signed [11:0] w_up;
    logic               w_oob;
    logic               w_is_wasd;
    logic signed [1:0]  w_key_mx;
    logic signed [1:0]  w_key_my;
    logic               w_space_rise;

    always_comb begin
        w_x     = $signed({2'b00, r_x});
        w_y     = $signed({2'b00, r_y});
        w_nx    = w_x + $signed({{10{r_mx[1]}}, r_mx});
        w_ny    = w_y + $signed({{10{r_my[1]}}, r_my});
        w_left  = w_x - c_STEP;
        w_down  = w_y + c_STEP;
        w_right = w_x + c_STEP;
        w_up    = w_y - c_STEP;
        // Bounds are judged on where the sprite would land, not where it is
        w_oob   = (w_nx + c_SIZE >= c_X_MAX) || (w_nx - c_SIZE <= 12'sd0) ||
                  (w_ny + c_SIZE >= c_Y_MAX) || (w_ny - c_SIZE <= 12'sd0);
        w_space_rise = (keycode == c_KEY_SPACE) && (r_prev_key != c_KEY_SPACE);

        w_is_wasd = 1'b1;
        w_key_mx  = 2'sd0;
        w_key_my  = 2'sd0;
        case (keycode)
            c_KEY_A: w_key_mx = -2'sd1;
            c_KEY_D: w_key_mx =  2'sd1;
            c_KEY_W: w_key_my = -2'sd1;
            c_KEY_S: w_key_my =  2'sd1;
            default: w_is_wasd = 1'b0;
        endcase
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_state    <= S_MANUAL;
            r_x        <= c_X_CENTER[9:0];
            r_y        <= c_Y_CENTER[9:0];
            r_mx       <= 2'sd0;
            r_my       <= 2'sd0;
            r_prev_key <= 8'h00;
            r_auto     <= 1'b0;
            r_lap      <= '0;
            r_lap_done <= 1'b0;
            r_oob      <= 1'b0;
        end else begin
            r_prev_key <= keycode;
            r_lap_done <= 1'b0;
            r_oob      <= 1'b0;
            if (Run) begin
                if (keycode == c_KEY_ESC) begin
                    r_mx    <= 2'sd0;
                    r_my    <= 2'sd0;
                    r_state <= S_MANUAL;
                    r_auto  <= 1'b0;
                end else if (r_state != S_MANUAL && w_is_wasd) begin
                    r_mx    <= w_key_mx;
                    r_my    <= w_key_my;
                    r_state <= S_MANUAL;
                    r_auto  <= 1'b0;
                end else if (r_state == S_MANUAL && w_space_rise) begin
                    r_x     <= c_TRACK_R[9:0];
                    r_y     <= c_TRACK_T[9:0];
                    r_mx    <= 2'sd0;
                    r_my    <= 2'sd0;
                    r_state <= S_LEFT;
                    r_auto  <= 1'b1;
                end else begin
                    case (r_state)
                        S_MANUAL: begin
                            // Recentre wins over both the step and a new key's motion
                            if (w_oob) begin
                                r_x   <= c_X_CENTER[9:0];
                                r_y   <= c_Y_CENTER[9:0];
                                r_mx  <= 2'sd0;
                                r_my  <= 2'sd0;
                                r_oob <= 1'b1;
                            end else begin
                                r_x <= w_nx[9:0];
                                r_y <= w_ny[9:0];
                                if (w_is_wasd) begin
                                    r_mx <= w_key_mx;
                                    r_my <= w_key_my;
                                end
                            end
                        end
                        S_LEFT: begin
                            if (w_left <= c_TRACK_L) begin
                                r_x     <= c_TRACK_L[9:0];
                                r_state <= S_DOWN;
                            end else begin
                                r_x <= w_left[9:0];
                            end
                        end
                        S_DOWN: begin
                            if (w_down >= c_TRACK_B) begin
                                r_y     <= c_TRACK_B[9:0];
                                r_state <= S_RIGHT;
                            end else begin
                                r_y <= w_down[9:0];
                            end
                        end
                        S_RIGHT: begin
                            if (w_right >= c_TRACK_R) begin
                                r_x     <= c_TRACK_R[9:0];
                                r_state <= S_UP;
                            end else begin
                                r_x <= w_right[9:0];
                            end
                        end
                        S_UP: begin
                            if (w_up <= c_TRACK_T) begin
                                r_y        <= c_TRACK_T[9:0];
                                r_state    <= S_LEFT;
                                r_lap      <= r_lap + 1'b1;
                                r_lap_done <= 1'b1;
                            end else begin
                                r_y <= w_up[9:0];
                            end
                        end
                        default: begin
                            r_state <= S_MANUAL;
                            r_auto  <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign BallX       = r_x;
    assign BallY       = r_y;
    assign BallS       = 10'(SIZE);
    assign dir         = r_state;
    assign auto_active = r_auto;
    assign lap_count   = r_lap;
    assign lap_done    = r_lap_done;
    assign oob         = r_oob;

endmodule
`default_nettype wire

// File: tb/tb_track_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_track_sequencer: directed + random stimulus against a behavioural model |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_track_sequencer;

    logic       frame_clk;
    logic       Reset;
    logic       Run;
    logic [7:0] keycode;
    logic [9:0] BallX;
    logic [9:0] BallY;
    logic [9:0] BallS;
    logic [2:0] dir;
    logic       auto_active;
    logic [7:0] lap_count;
    logic       lap_done;
    logic       oob;

    track_sequencer dut (
        .frame_clk  (frame_clk),
        .Reset      (Reset),
        .Run        (Run),
        .keycode    (keycode),
        .BallX      (BallX),
        .BallY      (BallY),
        .BallS      (BallS),
        .dir        (dir),
        .auto_active(auto_active),
        .lap_count  (lap_count),
        .lap_done   (lap_done),
        .oob        (oob)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    int errors = 0;
    int checks = 0;

    // Reference state: position, motion, mode (0 manual, 1..4 legs), laps, pulses
    int         m_x, m_y, m_mx, m_my, m_dir, m_lap, m_ld, m_oob;
    logic [7:0] m_prev;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("BallX", 32'(BallX), m_x);
        chk("BallY", 32'(BallY), m_y);
        chk("BallS", 32'(BallS), 8);
        chk("dir", 32'(dir), m_dir);
        chk("auto_active", 32'(auto_active), (m_dir != 0) ? 1 : 0);
        chk("lap_count", 32'(lap_count), m_lap % 256);
        chk("lap_done", 32'(lap_done), m_ld);
        chk("oob", 32'(oob), m_oob);
    endtask

    task automatic model_reset();
        m_x = 370; m_y = 190; m_mx = 0; m_my = 0;
        m_dir = 0; m_lap = 0; m_ld = 0; m_oob = 0; m_prev = 8'h00;
    endtask

    // Move one axis value toward a target by at most STEP (=1)
    function automatic int approach(input int p, input int t);
        if (t - p >= -1 && t - p <= 1) return t;
        return (t > p) ? p + 1 : p - 1;
    endfunction

    task automatic model_step(input logic [7:0] k, input logic run);
        int  kmx, kmy, nx, ny, tx, ty;
        bit  wasd;
        m_ld = 0; m_oob = 0;
        kmx = 0; kmy = 0;
        wasd = 1;
        case (k)
            8'h04: kmx = -1;
            8'h07: kmx = 1;
            8'h1A: kmy = -1;
            8'h16: kmy = 1;
            default: wasd = 0;
        endcase
        if (run) begin
            if (k == 8'h29) begin
                m_mx = 0; m_my = 0; m_dir = 0;
            end else if (m_dir != 0 && wasd) begin
                m_dir = 0; m_mx = kmx; m_my = kmy;
            end else if (m_dir == 0 && k == 8'h2C && m_prev != 8'h2C) begin
                m_x = 370; m_y = 190; m_mx = 0; m_my = 0; m_dir = 1;
            end else if (m_dir == 0) begin
                nx = m_x + m_mx;
                ny = m_y + m_my;
                if (nx + 8 >= 639 || nx - 8 <= 0 || ny + 8 >= 479 || ny - 8 <= 0) begin
                    m_x = 370; m_y = 190; m_mx = 0; m_my = 0; m_oob = 1;
                end else begin
                    m_x = nx; m_y = ny;
                    if (wasd) begin m_mx = kmx; m_my = kmy; end
                end
            end else begin
                // Each leg heads for the corner that ends it
                case (m_dir)
                    1: begin tx = 270; ty = 190; end
                    2: begin tx = 270; ty = 290; end
                    3: begin tx = 370; ty = 290; end
                    default: begin tx = 370; ty = 190; end
                endcase
                m_x = approach(m_x, tx);
                m_y = approach(m_y, ty);
                if (m_x == tx && m_y == ty) begin
                    if (m_dir == 4) begin m_lap++; m_ld = 1; end
                    m_dir = (m_dir % 4) + 1;
                end
            end
        end
        m_prev = k;
    endtask

    task automatic tick(input logic [7:0] k, input logic run);
        keycode = k;
        Run = run;
        @(posedge frame_clk);
        model_step(k, run);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        #2;
        Reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge frame_clk);
        Reset = 1'b0;
    endtask

    initial begin
        int         sx, sy, last_x, r;
        logic [7:0] k;
        logic [7:0] held;
        Reset = 1'b0; Run = 1'b0; keycode = 8'h00;
        model_reset();

        // Asynchronous reset before any clock edge
        do_reset();
        chk("rst_x", 32'(BallX), 370);
        chk("rst_y", 32'(BallY), 190);

        // D held from reset: motion lands one edge late
        tick(8'h07, 1'b1); chk("d_e1_x", 32'(BallX), 370);
        tick(8'h07, 1'b1); chk("d_e2_x", 32'(BallX), 371);
        tick(8'h07, 1'b1); chk("d_e3_x", 32'(BallX), 372);
        for (int i = 0; i < 3; i++) tick(8'h00, 1'b1);
        chk("d_release_x", 32'(BallX), 375);

        // One-edge Space, then a full lap
        tick(8'h2C, 1'b1);
        chk("sp_dir", 32'(dir), 1);
        chk("sp_x", 32'(BallX), 370);
        for (int i = 0; i < 100; i++) tick(8'h00, 1'b1);
        chk("left_x", 32'(BallX), 270);
        chk("left_dir", 32'(dir), 2);
        for (int i = 0; i < 300; i++) tick(8'h00, 1'b1);
        chk("lap_x", 32'(BallX), 370);
        chk("lap_y", 32'(BallY), 190);
        chk("lap_dir", 32'(dir), 1);
        chk("lap_cnt", 32'(lap_count), 1);
        chk("lap_pulse", 32'(lap_done), 1);
        tick(8'h00, 1'b1);
        chk("lap_pulse_end", 32'(lap_done), 0);

        // Space held for 5 edges enters auto once
        tick(8'h29, 1'b1);
        chk("esc_dir", 32'(dir), 0);
        for (int i = 0; i < 5; i++) tick(8'h2C, 1'b1);
        chk("hold_sp_x", 32'(BallX), 366);
        chk("hold_sp_dir", 32'(dir), 1);
        for (int i = 0; i < 1000 && m_dir != 3; i++) tick(8'h00, 1'b1);
        for (int i = 0; i < 5; i++) tick(8'h00, 1'b1);
        tick(8'h16, 1'b1);
        chk("s_in_auto_dir", 32'(dir), 0);
        sy = int'(BallY);
        tick(8'h00, 1'b1);
        chk("s_next_y", 32'(BallY), sy + 1);

        // A held until the left bound forces a recentre
        tick(8'h29, 1'b1);
        last_x = int'(BallX);
        for (int i = 0; i < 800 && m_oob == 0; i++) begin
            last_x = int'(BallX);
            tick(8'h04, 1'b1);
        end
        chk("a_last_x", last_x, 9);
        chk("a_oob", 32'(oob), 1);
        chk("a_recentre_x", 32'(BallX), 370);
        tick(8'h00, 1'b1);
        chk("a_oob_end", 32'(oob), 0);
        chk("a_motion0_x", 32'(BallX), 370);

        // Run=0 freezes mid AUTO_DOWN
        tick(8'h2C, 1'b1);
        for (int i = 0; i < 1000 && m_dir != 2; i++) tick(8'h00, 1'b1);
        for (int i = 0; i < 5; i++) tick(8'h00, 1'b1);
        sx = int'(BallX); sy = int'(BallY);
        for (int i = 0; i < 10; i++) tick(8'h00, 1'b0);
        chk("frz_y", 32'(BallY), sy);
        chk("frz_dir", 32'(dir), 2);
        tick(8'h00, 1'b1);
        chk("resume_y", 32'(BallY), sy + 1);
        tick(8'h29, 1'b1);
        sx = int'(BallX); sy = int'(BallY);
        for (int i = 0; i < 3; i++) tick(8'h00, 1'b1);
        chk("esc_frz_x", 32'(BallX), sx);
        chk("esc_frz_y", 32'(BallY), sy);
        chk("esc_frz_dir", 32'(dir), 0);

        // Random keys and Run, with one asynchronous reset mid-run
        held = 8'h00;
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset();
            r = int'($urandom_range(0, 19));
            case (r)
                0, 1, 2, 3, 4, 5, 6, 7: k = 8'h00;
                8:  k = 8'h04;
                9:  k = 8'h07;
                10: k = 8'h1A;
                11: k = 8'h16;
                12: k = 8'h29;
                13, 14: k = 8'h2C;
                15, 16: k = held;
                default: k = 8'($urandom_range(0, 255));
            endcase
            held = k;
            tick(k, ($urandom_range(0, 9) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
